id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the pipelined MIPS CPU. Sits directly downstream of the instruction decoder.
- Latches the decoder's control bundle together with operands, register addresses, immediate, funct and PC+4.
- Detects load-use hazards and stalls the PC and IF/ID stage for LOAD_STALL cycles while inserting bubbles.
- Squashes the instruction in decode on a taken-branch or jump flush from a later stage.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- LOAD_STALL, 1, number of bubble cycles per load-use hazard; legal range 1..3.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  IF/ID holds a real instruction.
- flush_i  in  1  squash the instruction in decode (branch taken or jump resolved).
- reg_write_i, alu_src_i, branch_i, jump_i, mem_read_i, mem_write_i  in  1 each  decoder control.
- alu_op_i  in  3  decoder ALU op.
- reg_dst_i  in  2  decoder RegDst.
- mem_to_reg_i  in  2  decoder MemtoReg.
- rs_data_i, rt_data_i, imm_i, pc_plus4_i  in  DATA_W each  operands, sign-extended immediate, PC+4.
- rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  register specifiers.
- funct_i  in  6  funct field.
- *_o (one per input above except valid_i/flush_i)  out  same widths  registered copies.
- valid_o  out  1  EX instruction is real (not a bubble).
- stall_o  out  1  combinational; freezes PC and IF/ID write-enable.

Behaviour:
- Reset (rst_i=0, async): every output register is 0 and valid_o=0; state RUN; stall counter 0. stall_o=0 while in reset.
- Latency: one cycle. Inputs sampled at edge N appear on *_o after edge N.
- Bubble definition: all control outputs 0 (alu_op_o=3'b000), all data/address/funct/pc outputs 0, valid_o=0.
- Hazard detect (combinational, RUN state only): hz = valid_i & valid_o & mem_read_o & (rt_addr_o!=0) & (rt_addr_o==rs_addr_i | (uses_rt & rt_addr_o==rt_addr_i)).
- uses_rt = ~alu_src_i | mem_write_i. This covers R-format, branches and sw; addi/slti/lw do not use rt as a source.
- stall_o = ~flush_i & ((state==RUN & hz) | state==STALL).
- Per-edge priority: flush_i > stall > normal.
- flush_i=1:
  - load bubble, state->RUN, counter->0, stall_o forced 0.
  - Flush aborts an in-progress stall.
- stall_o=1: load bubble. The upstream instruction is held by the PC/IF/ID freeze.
- State machine:
  - RUN, hz, no flush: if LOAD_STALL==1, stay RUN. Otherwise go to STALL with cnt=LOAD_STALL-1.
  - STALL: if cnt==1, go to RUN with cnt=0; else cnt--.
  - Total stall_o-high cycles per hazard = LOAD_STALL exactly.
  - After the stall, the ID/EX stage holds a bubble, so hz re-evaluates to 0 and the held instruction enters.
- Normal (no flush, no stall): valid_i=1 loads all inputs with valid_o=1. valid_i=0 loads a bubble.
- $zero: rt_addr_o==0 never causes a hazard.
- Back-to-back lw then dependent lw: the second lw stalls as normal. Stalls do not chain beyond LOAD_STALL per dependency.
- Reset asserted mid-stall: immediate return to reset values. stall_o drops asynchronously.
- No X propagation: all state is reset; unused alu_op encodings pass through unchanged.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0].
  - stall_cnt_o increments on each edge with stall_o=1. flush_cnt_o increments on each edge with flush_i=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then addi $8,$0,5 (op 8) with valid_i=1 -> next cycle reg_write_o=1, alu_src_o=1, alu_op_o=3, valid_o=1; stall_o stays 0.
- lw $9,0($8), then add $10,$9,$8 (LOAD_STALL=1) -> stall_o=1 for exactly 1 cycle; one bubble (valid_o=0, reg_write_o=0); add appears the following cycle with rs_addr_o=9.
- Same sequence with LOAD_STALL=3 -> stall_o high 3 consecutive cycles; 3 bubbles; then add issues; state returns to RUN.
- lw $0,0($8) followed by add $10,$0,$8 -> no stall (zero register).
- LOAD_STALL=3: hazard stall, then flush_i=1 in the 2nd stall cycle -> stall_o=0 that cycle, bubble loaded, state RUN; stall_cnt_o=2 and flush_cnt_o=1 with HAZ_PERF_CNT_EN.
- rst_i pulsed low mid-stall -> all outputs 0 and stall_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ============================================================================
// Module   : id_ex_hazard_reg
// Brief    : ID/EX pipeline register with load-use stall and flush squashing.
//            Optional perf counters enabled by macro HAZ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_reg #(
    parameter int DATA_W     = 32,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              reg_write_i,
    input  logic              alu_src_i,
    input  logic              branch_i,
    input  logic              jump_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        alu_op_i,
    input  logic [1:0]        reg_dst_i,
    input  logic [1:0]        mem_to_reg_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [5:0]        funct_i,
    output logic              reg_write_o,
    output logic              alu_src_o,
    output logic              branch_o,
    output logic              jump_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [2:0]        alu_op_o,
    output logic [1:0]        reg_dst_o,
    output logic [1:0]        mem_to_reg_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic [4:0]        rs_addr_o,
    output logic [4:0]        rt_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [5:0]        funct_o,
    output logic              valid_o,
`ifdef HAZ_PERF_CNT_EN
    output logic              stall_o,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
`else
    output logic              stall_o
`endif
);

    localparam logic [1:0] c_STALL_INIT = 2'(LOAD_STALL - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_uses_rt;
    logic       w_hz;
    logic       w_load;

    // addi/slti/lw write rt rather than read it, so only rs matters for them
    assign w_uses_rt = ~alu_src_i | mem_write_i;
    assign w_hz = valid_i & valid_o & mem_read_o & (rt_addr_o != 5'd0) &
                  ((rt_addr_o == rs_addr_i) | (w_uses_rt & (rt_addr_o == rt_addr_i)));

    assign stall_o = ~flush_i & (((r_state == ST_RUN) & w_hz) | (r_state == ST_STALL));
    assign w_load  = valid_i & ~stall_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The hazard cycle itself is the first bubble, so STALL covers the remaining LOAD_STALL-1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 2'd0;
        end else if (r_state == ST_RUN) begin
            if (w_hz && (LOAD_STALL > 1)) begin
                w_state_nxt = ST_STALL;
                w_cnt_nxt   = c_STALL_INIT;
            end
        end else begin
            if (r_cnt == 2'd1) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end else begin
                w_cnt_nxt = r_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || !w_load) begin
            reg_write_o  <= 1'b0;
            alu_src_o    <= 1'b0;
            branch_o     <= 1'b0;
            jump_o       <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            alu_op_o     <= 3'd0;
            reg_dst_o    <= 2'd0;
            mem_to_reg_o <= 2'd0;
            rs_data_o    <= '0;
            rt_data_o    <= '0;
            imm_o        <= '0;
            pc_plus4_o   <= '0;
            rs_addr_o    <= 5'd0;
            rt_addr_o    <= 5'd0;
            rd_addr_o    <= 5'd0;
            funct_o      <= 6'd0;
            valid_o      <= 1'b0;
        end else begin
            reg_write_o  <= reg_write_i;
            alu_src_o    <= alu_src_i;
            branch_o     <= branch_i;
            jump_o       <= jump_i;
            mem_read_o   <= mem_read_i;
            mem_write_o  <= mem_write_i;
            alu_op_o     <= alu_op_i;
            reg_dst_o    <= reg_dst_i;
            mem_to_reg_o <= mem_to_reg_i;
            rs_data_o    <= rs_data_i;
            rt_data_o    <= rt_data_i;
            imm_o        <= imm_i;
            pc_plus4_o   <= pc_plus4_i;
            rs_addr_o    <= rs_addr_i;
            rt_addr_o    <= rt_addr_i;
            rd_addr_o    <= rd_addr_i;
            funct_o      <= funct_i;
            valid_o      <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if (flush_i && (flush_cnt_o != 16'hFFFF)) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: vector table on a LOAD_STALL=1 instance,
// hand sequences for multi-cycle stall, flush and async reset on a LOAD_STALL=3 instance.
`default_nettype none

module tb_id_ex_hazard_reg;

    logic        clk;
    logic        rst_i;
    logic        valid_i, flush_i;
    logic        reg_write_i, alu_src_i, branch_i, jump_i, mem_read_i, mem_write_i;
    logic [2:0]  alu_op_i;
    logic [1:0]  reg_dst_i, mem_to_reg_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i, pc_plus4_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic [5:0]  funct_i;

    logic        a_reg_write, a_alu_src, a_branch, a_jump, a_mem_read, a_mem_write;
    logic [2:0]  a_alu_op;
    logic [1:0]  a_reg_dst, a_mem_to_reg;
    logic [31:0] a_rs_data, a_rt_data, a_imm, a_pc;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [5:0]  a_funct;
    logic        a_valid, a_stall;

    logic        b_reg_write, b_alu_src, b_branch, b_jump, b_mem_read, b_mem_write;
    logic [2:0]  b_alu_op;
    logic [1:0]  b_reg_dst, b_mem_to_reg;
    logic [31:0] b_rs_data, b_rt_data, b_imm, b_pc;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [5:0]  b_funct;
    logic        b_valid, b_stall;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    logic [161:0] in_b, a_b, b_b;
    assign in_b = {reg_write_i, alu_src_i, branch_i, jump_i, mem_read_i, mem_write_i,
                   alu_op_i, reg_dst_i, mem_to_reg_i, rs_data_i, rt_data_i, imm_i,
                   pc_plus4_i, rs_addr_i, rt_addr_i, rd_addr_i, funct_i};
    assign a_b = {a_reg_write, a_alu_src, a_branch, a_jump, a_mem_read, a_mem_write,
                  a_alu_op, a_reg_dst, a_mem_to_reg, a_rs_data, a_rt_data, a_imm,
                  a_pc, a_rs, a_rt, a_rd, a_funct};
    assign b_b = {b_reg_write, b_alu_src, b_branch, b_jump, b_mem_read, b_mem_write,
                  b_alu_op, b_reg_dst, b_mem_to_reg, b_rs_data, b_rt_data, b_imm,
                  b_pc, b_rs, b_rt, b_rd, b_funct};

    id_ex_hazard_reg #(.DATA_W(32), .LOAD_STALL(1)) u1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .reg_write_i(reg_write_i), .alu_src_i(alu_src_i), .branch_i(branch_i),
        .jump_i(jump_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .alu_op_i(alu_op_i), .reg_dst_i(reg_dst_i), .mem_to_reg_i(mem_to_reg_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .pc_plus4_i(pc_plus4_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .funct_i(funct_i),
        .reg_write_o(a_reg_write), .alu_src_o(a_alu_src), .branch_o(a_branch),
        .jump_o(a_jump), .mem_read_o(a_mem_read), .mem_write_o(a_mem_write),
        .alu_op_o(a_alu_op), .reg_dst_o(a_reg_dst), .mem_to_reg_o(a_mem_to_reg),
        .rs_data_o(a_rs_data), .rt_data_o(a_rt_data), .imm_o(a_imm), .pc_plus4_o(a_pc),
        .rs_addr_o(a_rs), .rt_addr_o(a_rt), .rd_addr_o(a_rd), .funct_o(a_funct),
        .valid_o(a_valid),
        .stall_o(a_stall)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
`endif
    );

    id_ex_hazard_reg #(.DATA_W(32), .LOAD_STALL(3)) u3 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .reg_write_i(reg_write_i), .alu_src_i(alu_src_i), .branch_i(branch_i),
        .jump_i(jump_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .alu_op_i(alu_op_i), .reg_dst_i(reg_dst_i), .mem_to_reg_i(mem_to_reg_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .pc_plus4_i(pc_plus4_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .funct_i(funct_i),
        .reg_write_o(b_reg_write), .alu_src_o(b_alu_src), .branch_o(b_branch),
        .jump_o(b_jump), .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
        .alu_op_o(b_alu_op), .reg_dst_o(b_reg_dst), .mem_to_reg_o(b_mem_to_reg),
        .rs_data_o(b_rs_data), .rt_data_o(b_rt_data), .imm_o(b_imm), .pc_plus4_o(b_pc),
        .rs_addr_o(b_rs), .rt_addr_o(b_rt), .rd_addr_o(b_rd), .funct_o(b_funct),
        .valid_o(b_valid),
        .stall_o(b_stall)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid, flush, rw, asrc, mr, mw;
        logic [2:0] op;
        logic [4:0] rs, rt, rd;
        logic       exp_stall, exp_load;
    } vec_t;

    function automatic vec_t mk(input logic v, f, rw, asrc, mr, mw, input logic [2:0] op,
                                input logic [4:0] rs, rt, rd, input logic es, el);
        vec_t t;
        t.valid = v; t.flush = f; t.rw = rw; t.asrc = asrc; t.mr = mr; t.mw = mw;
        t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.exp_stall = es; t.exp_load = el;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input vec_t t, input int tag);
        valid_i      = t.valid;
        flush_i      = t.flush;
        reg_write_i  = t.rw;
        alu_src_i    = t.asrc;
        mem_read_i   = t.mr;
        mem_write_i  = t.mw;
        alu_op_i     = t.op;
        rs_addr_i    = t.rs;
        rt_addr_i    = t.rt;
        rd_addr_i    = t.rd;
        reg_dst_i    = {1'b0, ~t.asrc};
        mem_to_reg_i = {1'b0, t.mr};
        branch_i     = tag[1];
        jump_i       = tag[0];
        rs_data_i    = 32'hA000_0000 | tag;
        rt_data_i    = 32'hB000_0000 | tag;
        imm_i        = 32'hFFFF_FF00 | tag;
        pc_plus4_i   = 32'h0040_0000 + 32'(tag * 4);
        funct_i      = 6'h20 ^ tag[5:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b0;
        #2 rst_i = 1'b1;
        tick();
    endtask

    vec_t vecs[27];
    vec_t lw9, add9, idle;

    initial begin
        //            v f rw as mr mw op   rs  rt  rd  stall load
        vecs[0]  = mk(1,0,1, 1, 0, 0, 3'd3, 0,  8,  0, 0, 1);
        vecs[1]  = mk(1,0,1, 1, 1, 0, 3'd0, 8,  9,  0, 0, 1);
        vecs[2]  = mk(1,0,1, 0, 0, 0, 3'd2, 9,  8, 10, 1, 0);
        vecs[3]  = mk(1,0,1, 0, 0, 0, 3'd2, 9,  8, 10, 0, 1);
        vecs[4]  = mk(1,0,1, 1, 1, 0, 3'd0, 8,  0,  0, 0, 1);
        vecs[5]  = mk(1,0,1, 0, 0, 0, 3'd2, 0,  8, 10, 0, 1);
        vecs[6]  = mk(1,0,1, 1, 1, 0, 3'd0, 8, 11,  0, 0, 1);
        vecs[7]  = mk(1,0,1, 1, 0, 0, 3'd3, 11, 12, 0, 1, 0);
        vecs[8]  = mk(1,0,1, 1, 0, 0, 3'd3, 11, 12, 0, 0, 1);
        vecs[9]  = mk(1,0,1, 1, 1, 0, 3'd0, 8, 13,  0, 0, 1);
        vecs[10] = mk(1,0,0, 1, 0, 1, 3'd0, 8, 13,  0, 1, 0);
        vecs[11] = mk(1,0,0, 1, 0, 1, 3'd0, 8, 13,  0, 0, 1);
        vecs[12] = mk(1,0,1, 1, 1, 0, 3'd0, 8, 14,  0, 0, 1);
        vecs[13] = mk(1,0,1, 1, 0, 0, 3'd3, 8, 14,  0, 0, 1);
        vecs[14] = mk(1,0,1, 1, 1, 0, 3'd0, 8, 16,  0, 0, 1);
        vecs[15] = mk(1,1,1, 0, 0, 0, 3'd2, 8, 16, 10, 0, 0);
        vecs[16] = mk(0,0,1, 0, 0, 0, 3'd2, 16, 8, 10, 0, 0);
        vecs[17] = mk(1,0,1, 1, 1, 0, 3'd0, 8, 17,  0, 0, 1);
        vecs[18] = mk(0,0,1, 0, 0, 0, 3'd2, 17, 8, 10, 0, 0);
        vecs[19] = mk(1,0,1, 1, 1, 0, 3'd0, 8, 18,  0, 0, 1);
        vecs[20] = mk(1,0,1, 1, 1, 0, 3'd0, 18, 19, 0, 1, 0);
        vecs[21] = mk(1,0,1, 1, 1, 0, 3'd0, 18, 19, 0, 0, 1);
        vecs[22] = mk(1,0,1, 0, 0, 0, 3'd7, 19, 8, 20, 1, 0);
        vecs[23] = mk(1,0,1, 0, 0, 0, 3'd7, 19, 8, 20, 0, 1);
        vecs[24] = mk(1,0,1, 1, 1, 0, 3'd0, 8, 21,  0, 0, 1);
        vecs[25] = mk(1,0,1, 0, 0, 0, 3'd2, 8, 21, 22, 1, 0);
        vecs[26] = mk(1,0,1, 0, 0, 0, 3'd2, 8, 21, 22, 0, 1);
        lw9  = mk(1,0,1,1,1,0,3'd0, 8, 9, 0, 0, 1);
        add9 = mk(1,0,1,0,0,0,3'd2, 9, 8, 10, 0, 1);
        idle = mk(0,0,0,0,0,0,3'd0, 0, 0, 0, 0, 0);

        // Reset state while inputs present a valid instruction
        rst_i = 1'b0;
        set_in(vecs[0], 0);
        #2;
        chk("reset_bundle_u1", a_b, '0);
        chk("reset_valid_u3", {161'd0, b_valid}, 162'd0);
        chk("reset_stall_u1", {161'd0, a_stall}, 162'd0);
        #10 rst_i = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            logic [161:0] exp_b;
            set_in(vecs[i], i);
            #1;
            chk($sformatf("vec%0d_stall", i), {161'd0, a_stall}, {161'd0, vecs[i].exp_stall});
            exp_b = vecs[i].exp_load ? in_b : '0;
            tick();
            chk($sformatf("vec%0d_bundle", i), a_b, exp_b);
            chk($sformatf("vec%0d_valid", i), {161'd0, a_valid}, {161'd0, vecs[i].exp_load});
        end

        // LOAD_STALL=3: three stall cycles, three bubbles, then the held add issues
        do_reset();
        set_in(lw9, 1); tick();
        set_in(add9, 2); #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ls3_stall_c%0d", c), {161'd0, b_stall}, {161'd0, 1'b1});
            tick();
            chk($sformatf("ls3_bubble_c%0d", c), {b_b[161:1], b_valid}, '0);
        end
        chk("ls3_stall_end", {161'd0, b_stall}, 162'd0);
        tick();
        chk("ls3_add_valid", {161'd0, b_valid}, {161'd0, 1'b1});
        chk("ls3_add_rs", {157'd0, b_rs}, {157'd0, 5'd9});
        set_in(idle, 0); #1;
        chk("ls3_run_after", {161'd0, b_stall}, 162'd0);

        // LOAD_STALL=3: flush in the second cycle spent in STALL aborts it
        do_reset();
        set_in(lw9, 1); tick();
        set_in(add9, 2); tick(); tick();
        chk("fl_stall_before", {161'd0, b_stall}, {161'd0, 1'b1});
        flush_i = 1'b1; #1;
        chk("fl_stall_forced0", {161'd0, b_stall}, 162'd0);
        tick();
        chk("fl_bubble", {b_b[161:1], b_valid}, '0);
        flush_i = 1'b0; #1;
        chk("fl_state_run", {161'd0, b_stall}, 162'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("fl_stall_cnt", {146'd0, b_scnt}, {146'd0, 16'd2});
        chk("fl_flush_cnt", {146'd0, b_fcnt}, {146'd0, 16'd1});
`endif

        // Asynchronous reset while the hazard is flagged and while in STALL
        do_reset();
        set_in(lw9, 1); tick();
        set_in(add9, 2); #1;
        chk("ar_pre_stall", {161'd0, b_stall}, {161'd0, 1'b1});
        chk("ar_pre_valid", {161'd0, b_valid}, {161'd0, 1'b1});
        #1 rst_i = 1'b0; #1;
        chk("ar_stall_u3", {161'd0, b_stall}, 162'd0);
        chk("ar_bundle_u3", {b_b[161:1], b_valid}, '0);
        chk("ar_bundle_u1", {a_b[161:1], a_valid}, '0);
        #1 rst_i = 1'b1;
        tick();
        set_in(lw9, 1); tick();
        set_in(add9, 2); tick();
        chk("ar2_in_stall", {161'd0, b_stall}, {161'd0, 1'b1});
        #2 rst_i = 1'b0; #1;
        chk("ar2_stall_drop", {161'd0, b_stall}, 162'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("ar2_cnt_clear", {130'd0, b_scnt, b_fcnt}, 162'd0);
`endif
        #1 rst_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
